// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor controller.
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

    localparam int SA_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic element of the serial datapath.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sout,
    output logic Cout
);

    assign Sout = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: latches operands on start, ripples LSB first through one
// full adder with a registered carry, and reports sum, carry-out and signed overflow.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    // Holds the WIDTH-1 bits already produced; the current bit completes the word.
    logic [WIDTH-2:0] s_sr_q, s_sr_d;
    logic             c_q, c_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] s_cat;
    logic             cnt_carry;

    full_adder u_full_adder (
        .A    (a_sr_q[0]),
        .B    (b_sr_q[0]),
        .Cin  (c_q),
        .Sout (fa_sum),
        .Cout (fa_cout)
    );

    assign s_cat = {fa_sum, s_sr_q};

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        s_sr_d    = s_sr_q;
        c_d       = c_q;
        bit_cnt_d = bit_cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        cnt_carry = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_sr_d    = a_i;
                    // Subtraction is A + ~B + 1.
                    b_sr_d    = b_i ^ {WIDTH{sub_i}};
                    c_d       = sub_i ? 1'b1 : cin_i;
                    s_sr_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                s_sr_d = s_cat[WIDTH-1:1];
                c_d    = fa_cout;
                if (bit_cnt_q == LastCnt) begin
                    sum_d   = s_cat;
                    cout_d  = fa_cout;
                    // c_q is the carry into the MSB on this cycle.
                    ovf_d   = c_q ^ fa_cout;
                    state_d = DONE;
                end else begin
                    for (int i = 0; i < int'(CntW); i++) begin
                        bit_cnt_d[i] = bit_cnt_q[i] ^ cnt_carry;
                        cnt_carry    = cnt_carry & bit_cnt_q[i];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            s_sr_q    <= '0;
            c_q       <= 1'b0;
            bit_cnt_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            s_sr_q    <= s_sr_d;
            c_q       <= c_d;
            bit_cnt_q <= bit_cnt_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases plus random operations
// checked against an integer-arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         cin_i = 1'b0;
    logic         sub_i = 1'b0;
    logic         ready_o, busy_o, done_o, cout_o, ovf_o;
    logic [W-1:0] sum_o;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
        .sub_i   (sub_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                  input logic sub, output logic [7:0] s, output logic co,
                                  output logic ov);
        int r;
        if (sub) begin
            r  = int'(a) - int'(b);
            s  = r[7:0];
            co = (a >= b);
            ov = (a[7] != b[7]) && (s[7] != a[7]);
        end else begin
            r  = int'(a) + int'(b) + int'(cin);
            s  = r[7:0];
            co = r[8];
            ov = (a[7] == b[7]) && (s[7] != a[7]);
        end
    endfunction

    // Issue one operation from IDLE; returns results and negedges from acceptance to done.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, output logic [7:0] s, output logic co,
                          output logic ov, output int lat);
        @(negedge clk);
        start_i = 1'b1; a_i = a; b_i = b; cin_i = cin; sub_i = sub;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        s = sum_o; co = cout_o; ov = ovf_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready_o, busy_o, done_o, sum_o, cout_o, ovf_o} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy=%b busy=%b done=%b sum=%h co=%b ov=%b required 1 0 0 00 0 0",
                     ready_o, busy_o, done_o, sum_o, cout_o, ovf_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_ovf();
        logic [7:0] s; logic co, ov; int lat;
        bit stable = 1'b1;
        bit busy_ok = 1'b1;
        @(negedge clk);
        start_i = 1'b1; a_i = 8'h5A; b_i = 8'h3C; cin_i = 1'b0; sub_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 30) begin
            if (!busy_o || ready_o) busy_ok = 1'b0;
            if (sum_o !== 8'h00) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        s = sum_o; co = cout_o; ov = ovf_o;
        checks++;
        if ({s, co, ov} !== {8'h96, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_ovf: got %h/%b/%b required 96/0/1", s, co, ov);
        end
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL add_latency: got %0d required 9", lat);
        end
        checks++;
        if (!busy_ok || !stable) begin
            errors++;
            $display("FAIL run_phase: busy_ok=%b sum_stable=%b required 1 1", busy_ok, stable);
        end
        @(negedge clk);
        checks++;
        if ({done_o, ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL done_pulse: done=%b ready=%b required 0 1", done_o, ready_o);
        end
    endtask

    task automatic test_carry_wrap();
        logic [7:0] s; logic co, ov; int lat;
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_ff_01: got %h/%b/%b required 00/1/0", s, co, ov);
        end
        run_op(8'h7F, 8'h00, 1'b1, 1'b0, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'h80, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_cin: got %h/%b/%b required 80/0/1", s, co, ov);
        end
    endtask

    task automatic test_sub();
        logic [7:0] s; logic co, ov; int lat;
        run_op(8'h10, 8'h20, 1'b0, 1'b1, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'hF0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_10_20: got %h/%b/%b required F0/0/0", s, co, ov);
        end
        run_op(8'h80, 8'h01, 1'b0, 1'b1, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'h7F, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_80_01: got %h/%b/%b required 7F/1/1", s, co, ov);
        end
        run_op(8'h80, 8'h01, 1'b1, 1'b1, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'h7F, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_cin_ignored: got %h/%b/%b required 7F/1/1", s, co, ov);
        end
    endtask

    task automatic test_ignored_start();
        int lat = 1;
        bit extra_done = 1'b0;
        @(negedge clk);
        start_i = 1'b1; a_i = 8'h11; b_i = 8'h22; cin_i = 1'b0; sub_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        lat = 4;
        start_i = 1'b1; a_i = 8'hF0; b_i = 8'h0F; cin_i = 1'b1;
        @(negedge clk);
        lat++;
        start_i = 1'b0;
        while (!done_o && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if ({sum_o, cout_o, ovf_o, lat} !== {8'h33, 1'b0, 1'b0, 32'd9}) begin
            errors++;
            $display("FAIL ignored_start: got %h/%b/%b lat %0d required 33/0/0 lat 9",
                     sum_o, cout_o, ovf_o, lat);
        end
        repeat (12) begin
            @(negedge clk);
            if (done_o || busy_o) extra_done = 1'b1;
        end
        checks++;
        if (extra_done) begin
            errors++;
            $display("FAIL no_queue: got extra activity 1 required 0");
        end
    endtask

    task automatic test_back_to_back();
        int done_at[$];
        bit stable = 1'b1;
        @(negedge clk);
        start_i = 1'b1; a_i = 8'h21; b_i = 8'h13; cin_i = 1'b0; sub_i = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a_i = 8'h40; b_i = 8'h05;
            end
            if (done_o) done_at.push_back(k);
            if (k >= 10 && k <= 18 && sum_o !== 8'h34) stable = 1'b0;
            if (k == 19 && sum_o !== 8'h45) stable = 1'b0;
        end
        start_i = 1'b0;
        checks++;
        if (done_at.size() != 3 || done_at[0] != 9 || done_at[1] != 19 || done_at[2] != 29) begin
            errors++;
            $display("FAIL held_start: got %0d pulses first at %0d required 3 pulses at 9,19,29",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL sum_stable: got unstable sum required 34 until second done then 45");
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [7:0] s; logic co, ov; int lat;
        bit saw_done = 1'b0;
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, s, co, ov, lat);
        @(negedge clk);
        start_i = 1'b1; a_i = 8'h33; b_i = 8'h44;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready_o, busy_o, done_o, sum_o, cout_o, ovf_o} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b busy=%b done=%b sum=%h co=%b ov=%b required 1 0 0 00 0 0",
                     ready_o, busy_o, done_o, sum_o, cout_o, ovf_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done_o) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL aborted_done: got done pulse 1 required 0");
        end
        run_op(8'h01, 8'h02, 1'b0, 1'b0, s, co, ov, lat);
        checks++;
        if ({s, co, ov, lat} !== {8'h03, 1'b0, 1'b0, 32'd9}) begin
            errors++;
            $display("FAIL after_reset: got %h/%b/%b lat %0d required 03/0/0 lat 9", s, co, ov, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, s, es; logic cin, sub, co, ov, eco, eov; int lat;
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom); b = 8'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            model(a, b, cin, sub, es, eco, eov);
            run_op(a, b, cin, sub, s, co, ov, lat);
            checks++;
            if ({s, co, ov, lat} !== {es, eco, eov, 32'd9}) begin
                errors++;
                $display("FAIL random %h%s%h cin=%b: got %h/%b/%b lat %0d required %h/%b/%b lat 9",
                         a, sub ? "-" : "+", b, cin, s, co, ov, lat, es, eco, eov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_carry_wrap();
        test_sub();
        test_ignored_start();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
